ping_pong_sequencer: RTL

Controller that sequences a 4-bit ping-pong counter. It drives the counter's enable at a programmable rate and watches the counter's direction output to count completed sweeps. After a commanded number of sweeps it stops the counter and reports completion. It sits between the control/register logic (start/stop/pause strobes, configuration) and the counter instance.

---
 rtl/ping_pong_sequencer_if.sv | 41 ++++
 rtl/ping_pong_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/ping_pong_sequencer_if.sv
// rtl/ping_pong_sequencer_if.sv - control and counter-side signals of ping_pong_sequencer
// Optional irq/irq_clr pair present when PPC_SEQ_STICKY_IRQ_EN is defined.
interface ping_pong_sequencer_if #(
   parameter int SW_W  = 8,
   parameter int DIV_W = 8
);
   logic             start;
   logic             stop;
   logic             pause;
   logic [SW_W-1:0]  num_sweeps;
   logic [DIV_W-1:0] rate;
   logic             cnt_dir;
   logic [3:0]       cnt_out;
   logic             cnt_enable;
   logic             busy;
   logic             done;
   logic [SW_W-1:0]  sweep_cnt;
   logic [3:0]       final_val;
`ifdef PPC_SEQ_STICKY_IRQ_EN
   logic             irq;
   logic             irq_clr;

   modport slave (
      input  start, stop, pause, num_sweeps, rate, cnt_dir, cnt_out, irq_clr,
      output cnt_enable, busy, done, sweep_cnt, final_val, irq
   );
   modport master (
      output start, stop, pause, num_sweeps, rate, cnt_dir, cnt_out, irq_clr,
      input  cnt_enable, busy, done, sweep_cnt, final_val, irq
   );
`else
   modport slave (
      input  start, stop, pause, num_sweeps, rate, cnt_dir, cnt_out,
      output cnt_enable, busy, done, sweep_cnt, final_val
   );
   modport master (
      output start, stop, pause, num_sweeps, rate, cnt_dir, cnt_out,
      input  cnt_enable, busy, done, sweep_cnt, final_val
   );
`endif
endinterface

// File: rtl/ping_pong_sequencer.sv
// rtl/ping_pong_sequencer.sv - runs a 4-bit ping-pong counter for a commanded number of sweeps
// Sticky completion interrupt (irq/irq_clr) enabled by defining PPC_SEQ_STICKY_IRQ_EN.
module ping_pong_sequencer #(
   parameter int SW_W  = 8,
   parameter int DIV_W = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   ping_pong_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t           state, state_nxt;
   logic [SW_W-1:0]  tgt, sweep_cnt, sweep_inc;
   logic [DIV_W-1:0] div, divider;
   logic [3:0]       final_val;
   logic             prev_dir;
   logic             accept, busy, reversal, complete, advance, cnt_enable, done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Priority: stop > completion > pause > divider tick.
   always_comb begin
      state_nxt  = state;
      cnt_enable = 1'b0;
      done       = 1'b0;
      advance    = 1'b0;
      busy       = (state == RUN) || (state == PAUSE);
      accept     = (state == IDLE) && bus.start && !bus.stop;
      reversal   = busy && (bus.cnt_dir != prev_dir);
      sweep_inc  = (&sweep_cnt) ? sweep_cnt : sweep_cnt + 1'b1;
      complete   = reversal && (sweep_inc == tgt);
      case (state)
         IDLE: begin
            if (accept) state_nxt = (bus.num_sweeps == '0) ? DONE : RUN;
         end
         RUN: begin
            if (bus.stop)       state_nxt = IDLE;
            else if (complete)  state_nxt = DONE;
            else if (bus.pause) state_nxt = PAUSE;
            else begin
               advance    = 1'b1;
               cnt_enable = (divider == div);
            end
         end
         PAUSE: begin
            if (bus.stop)        state_nxt = IDLE;
            else if (complete)   state_nxt = DONE;
            else if (!bus.pause) state_nxt = RUN;
         end
         DONE: begin
            done      = !bus.stop;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt       <= '0;
         div       <= '0;
         divider   <= '0;
         prev_dir  <= 1'b0;
         sweep_cnt <= '0;
         final_val <= 4'd0;
      end else begin
         if (accept) begin
            tgt       <= bus.num_sweeps;
            div       <= bus.rate;
            divider   <= '0;
            sweep_cnt <= '0;
            prev_dir  <= bus.cnt_dir;
         end
         if (busy) prev_dir <= bus.cnt_dir;
         if (reversal && !bus.stop) sweep_cnt <= sweep_inc;
         // Divider only moves on unpaused RUN cycles, so a pause freezes it in place.
         if (advance) divider <= cnt_enable ? '0 : divider + 1'b1;
         if (done) final_val <= bus.cnt_out;
      end
   end

`ifdef PPC_SEQ_STICKY_IRQ_EN
   logic irq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           irq <= 1'b0;
      else if (done)        irq <= 1'b1;
      else if (bus.irq_clr) irq <= 1'b0;
   end

   assign bus.irq = irq;
`endif

   assign bus.cnt_enable = cnt_enable;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.sweep_cnt  = sweep_cnt;
   assign bus.final_val  = final_val;
endmodule
